// File: rtl/port_stream_endpoint_if.sv
// port_stream_endpoint_if
// Bundles the host-side MMIO port words and the two valid/ready streams of
// one port_stream_endpoint.
//   port_d_out_0/1, port_inform_write/read : host -> endpoint
//   port_d_in_0/1                          : endpoint -> host
//   tx_data/tx_valid, tx_ready             : endpoint -> consumer stream
//   rx_data/rx_valid, rx_ready             : producer -> endpoint stream
// modport slave  : the endpoint itself
// modport master : the environment (host controller plus stream peers)
interface port_stream_endpoint_if;
  logic [15:0] port_d_out_0;
  logic [15:0] port_d_out_1;
  logic        port_inform_write;
  logic        port_inform_read;
  logic [15:0] port_d_in_0;
  logic [15:0] port_d_in_1;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;

  modport slave (
    input  port_d_out_0, port_d_out_1, port_inform_write, port_inform_read,
    input  tx_ready, rx_data, rx_valid,
    output port_d_in_0, port_d_in_1, tx_data, tx_valid, rx_ready
  );

  modport master (
    output port_d_out_0, port_d_out_1, port_inform_write, port_inform_read,
    output tx_ready, rx_data, rx_valid,
    input  port_d_in_0, port_d_in_1, tx_data, tx_valid, rx_ready
  );
endinterface

// File: rtl/port_stream_endpoint.sv
// port_stream_endpoint
// Device end of one MMIO port pair. Host writes to port word 0 are queued in
// a TX FIFO and drained to a valid/ready consumer; words from a valid/ready
// producer are queued in an RX FIFO whose head, plus a status word, are
// returned to the host as the two port input words.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous reset, active-high
//   bus  : port_stream_endpoint_if.slave (host port words + TX/RX streams)
// Control word (port_d_out_1, level): [0] tx_en, [1] rx_en, [2] clr_flags.
// Status word (port_d_in_1): [0] rx_nonempty, [1] tx_full, [2] tx_empty,
//   [3] rx_ovf (underflow, sticky), [4] tx_ovf (sticky), [15:8] rx_count.
module port_stream_endpoint #(
  parameter int unsigned DEPTH = 8
) (
  input logic                  clk,
  input logic                  rst,
  port_stream_endpoint_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  // Control decode
  logic tx_en, rx_en, clr_flags;
  assign tx_en     = bus.port_d_out_1[0];
  assign rx_en     = bus.port_d_out_1[1];
  assign clr_flags = bus.port_d_out_1[2];

  logic unused_ctrl_bits;
  assign unused_ctrl_bits = ^bus.port_d_out_1[15:3];

  // TX FIFO state
  logic [15:0]   tx_mem_q [DEPTH];
  logic [AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic          tx_ovf_q, tx_ovf_d;

  // RX FIFO state
  logic [15:0]   rx_mem_q [DEPTH];
  logic [AW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic          rx_ovf_q, rx_ovf_d;

  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_pop, tx_push, tx_drop;
  logic rx_push, rx_pop, rx_udf;

  assign tx_full  = (tx_cnt_q == CW'(DEPTH));
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == CW'(DEPTH));
  assign rx_empty = (rx_cnt_q == '0);

  // TX: a transfer in the same cycle frees the slot a full-FIFO push uses.
  // When full, wr and rd pointers coincide; the head is read out this cycle
  // and overwritten at the edge, so no word is lost.
  assign tx_pop  = bus.tx_valid & bus.tx_ready;
  assign tx_push = bus.port_inform_write & (~tx_full | tx_pop);
  assign tx_drop = bus.port_inform_write & tx_full & ~tx_pop;

  // RX: rx_ready uses the pre-pop full flag, so a full FIFO stalls the
  // producer even when the host pops in the same cycle.
  assign rx_push = bus.rx_valid & bus.rx_ready;
  assign rx_pop  = bus.port_inform_read & ~rx_empty;
  assign rx_udf  = bus.port_inform_read & rx_empty;

  // Outputs
  assign bus.tx_valid    = tx_en & ~tx_empty;
  assign bus.tx_data     = tx_mem_q[tx_rp_q];
  assign bus.rx_ready    = rx_en & ~rx_full;
  assign bus.port_d_in_0 = rx_empty ? '0 : rx_mem_q[rx_rp_q];
  assign bus.port_d_in_1 = {8'(rx_cnt_q), 3'b000, tx_ovf_q, rx_ovf_q,
                            tx_empty, tx_full, ~rx_empty};

  always_comb begin
    tx_wp_d  = tx_wp_q;
    tx_rp_d  = tx_rp_q;
    tx_cnt_d = tx_cnt_q;
    rx_wp_d  = rx_wp_q;
    rx_rp_d  = rx_rp_q;
    rx_cnt_d = rx_cnt_q;

    if (tx_push) tx_wp_d = tx_wp_q + AW'(1);
    if (tx_pop)  tx_rp_d = tx_rp_q + AW'(1);
    if (tx_push && !tx_pop)      tx_cnt_d = tx_cnt_q + CW'(1);
    else if (tx_pop && !tx_push) tx_cnt_d = tx_cnt_q - CW'(1);

    if (rx_push) rx_wp_d = rx_wp_q + AW'(1);
    if (rx_pop)  rx_rp_d = rx_rp_q + AW'(1);
    if (rx_push && !rx_pop)      rx_cnt_d = rx_cnt_q + CW'(1);
    else if (rx_pop && !rx_push) rx_cnt_d = rx_cnt_q - CW'(1);

    // Set wins over clear
    tx_ovf_d = tx_drop | (tx_ovf_q & ~clr_flags);
    rx_ovf_d = rx_udf  | (rx_ovf_q & ~clr_flags);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      tx_cnt_q <= '0;
      tx_ovf_q <= 1'b0;
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      rx_cnt_q <= '0;
      rx_ovf_q <= 1'b0;
    end else begin
      tx_wp_q  <= tx_wp_d;
      tx_rp_q  <= tx_rp_d;
      tx_cnt_q <= tx_cnt_d;
      tx_ovf_q <= tx_ovf_d;
      rx_wp_q  <= rx_wp_d;
      rx_rp_q  <= rx_rp_d;
      rx_cnt_q <= rx_cnt_d;
      rx_ovf_q <= rx_ovf_d;
    end
  end

  // Storage is not reset; contents are only visible through non-empty pointers.
  always_ff @(posedge clk) begin
    if (!rst && tx_push) tx_mem_q[tx_wp_q] <= bus.port_d_out_0;
    if (!rst && rx_push) rx_mem_q[rx_wp_q] <= bus.rx_data;
  end

endmodule

// File: tb/tb_port_stream_endpoint.sv
module tb_port_stream_endpoint;

  logic clk = 1'b0;
  logic rst;
  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  port_stream_endpoint_if bus();

  port_stream_endpoint #(.DEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Inputs change and outputs are checked at negedge, away from the active edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic push_tx(input logic [15:0] w);
    bus.port_d_out_0      = w;
    bus.port_inform_write = 1'b1;
    cyc();
    bus.port_inform_write = 1'b0;
  endtask

  task automatic pop_rx();
    bus.port_inform_read = 1'b1;
    cyc();
    bus.port_inform_read = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.port_d_out_0 = '0; bus.port_d_out_1 = '0;
    bus.port_inform_write = 1'b0; bus.port_inform_read = 1'b0;
    bus.tx_ready = 1'b0; bus.rx_data = '0; bus.rx_valid = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    n_total++;
    if (bus.port_d_in_1 !== 16'h0004) $display("FAIL reset_status got %h exp %h", bus.port_d_in_1, 16'h0004); else n_pass++;
    n_total++;
    if (bus.tx_valid !== 1'b0) $display("FAIL reset_tx_valid got %b exp 0", bus.tx_valid); else n_pass++;
    n_total++;
    if (bus.rx_ready !== 1'b0) $display("FAIL reset_rx_ready got %b exp 0", bus.rx_ready); else n_pass++;
    n_total++;
    if (bus.port_d_in_0 !== 16'h0000) $display("FAIL reset_d_in_0 got %h exp 0000", bus.port_d_in_0); else n_pass++;
  endtask

  task automatic test_tx_order();
    logic [15:0] exp_w [3];
    exp_w[0] = 16'h1111; exp_w[1] = 16'h2222; exp_w[2] = 16'h3333;
    bus.port_d_out_1 = 16'h0001;
    bus.tx_ready = 1'b0;
    push_tx(16'h1111);
    n_total++;
    if (bus.tx_valid !== 1'b1 || bus.tx_data !== 16'h1111)
      $display("FAIL tx_first got v=%b d=%h exp v=1 d=1111", bus.tx_valid, bus.tx_data); else n_pass++;
    push_tx(16'h2222);
    push_tx(16'h3333);
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== exp_w[i])
        $display("FAIL tx_order[%0d] got v=%b d=%h exp v=1 d=%h", i, bus.tx_valid, bus.tx_data, exp_w[i]); else n_pass++;
      cyc();
    end
    bus.tx_ready = 1'b0;
    n_total++;
    if (bus.port_d_in_1[2] !== 1'b1 || bus.tx_valid !== 1'b0)
      $display("FAIL tx_drained got empty=%b v=%b exp empty=1 v=0", bus.port_d_in_1[2], bus.tx_valid); else n_pass++;
  endtask

  task automatic test_tx_overflow();
    bus.port_d_out_1 = 16'h0001;
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) push_tx(16'h00A0 + 16'(i));
    n_total++;
    if (bus.port_d_in_1[1] !== 1'b1 || bus.port_d_in_1[4] !== 1'b1)
      $display("FAIL tx_ovf_flags got full=%b ovf=%b exp 1 1", bus.port_d_in_1[1], bus.port_d_in_1[4]); else n_pass++;
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_total++;
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== 16'h00A0 + 16'(i))
        $display("FAIL tx_ovf_drain[%0d] got v=%b d=%h exp v=1 d=%h", i, bus.tx_valid, bus.tx_data, 16'h00A0 + 16'(i)); else n_pass++;
      cyc();
    end
    bus.tx_ready = 1'b0;
    n_total++;
    if (bus.tx_valid !== 1'b0) $display("FAIL tx_ovf_ninth_dropped got v=%b exp 0", bus.tx_valid); else n_pass++;
    bus.port_d_out_1 = 16'h0005;
    cyc();
    bus.port_d_out_1 = 16'h0001;
    n_total++;
    if (bus.port_d_in_1[4] !== 1'b0) $display("FAIL tx_ovf_clear got %b exp 0", bus.port_d_in_1[4]); else n_pass++;
  endtask

  task automatic test_tx_full_simul();
    bus.port_d_out_1 = 16'h0001;
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_tx(16'h00B0 + 16'(i));
    // push and transfer in the same cycle while full
    bus.tx_ready = 1'b1;
    push_tx(16'h00B8);
    bus.tx_ready = 1'b0;
    n_total++;
    if (bus.port_d_in_1[1] !== 1'b1 || bus.port_d_in_1[4] !== 1'b0)
      $display("FAIL tx_simul_full got full=%b ovf=%b exp 1 0", bus.port_d_in_1[1], bus.port_d_in_1[4]); else n_pass++;
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_total++;
      if (bus.tx_data !== 16'h00B1 + 16'(i))
        $display("FAIL tx_simul_drain[%0d] got %h exp %h", i, bus.tx_data, 16'h00B1 + 16'(i)); else n_pass++;
      cyc();
    end
    bus.tx_ready = 1'b0;
    n_total++;
    if (bus.port_d_in_1[2] !== 1'b1) $display("FAIL tx_simul_empty got %b exp 1", bus.port_d_in_1[2]); else n_pass++;
  endtask

  task automatic test_rx_pop();
    bus.port_d_out_1 = 16'h0002;
    bus.rx_valid = 1'b1;
    bus.rx_data = 16'hBEEF; cyc();
    bus.rx_data = 16'hCAFE; cyc();
    bus.rx_valid = 1'b0;
    n_total++;
    if (bus.port_d_in_0 !== 16'hBEEF || bus.port_d_in_1[15:8] !== 8'd2)
      $display("FAIL rx_fill got d=%h cnt=%0d exp d=beef cnt=2", bus.port_d_in_0, bus.port_d_in_1[15:8]); else n_pass++;
    pop_rx();
    n_total++;
    if (bus.port_d_in_0 !== 16'hCAFE || bus.port_d_in_1[15:8] !== 8'd1)
      $display("FAIL rx_pop1 got d=%h cnt=%0d exp d=cafe cnt=1", bus.port_d_in_0, bus.port_d_in_1[15:8]); else n_pass++;
    pop_rx();
    n_total++;
    if (bus.port_d_in_0 !== 16'h0000 || bus.port_d_in_1[0] !== 1'b0)
      $display("FAIL rx_pop2 got d=%h nonempty=%b exp d=0000 nonempty=0", bus.port_d_in_0, bus.port_d_in_1[0]); else n_pass++;
    pop_rx();
    n_total++;
    if (bus.port_d_in_1 !== 16'h000C) $display("FAIL rx_underflow got %h exp 000c", bus.port_d_in_1); else n_pass++;
    bus.port_d_out_1 = 16'h0006;
    cyc();
    bus.port_d_out_1 = 16'h0002;
    n_total++;
    if (bus.port_d_in_1 !== 16'h0004) $display("FAIL rx_clear got %h exp 0004", bus.port_d_in_1); else n_pass++;
  endtask

  task automatic test_rx_full_reset();
    bus.port_d_out_1 = 16'h0002;
    bus.rx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.rx_data = 16'h00C0 + 16'(i);
      cyc();
    end
    bus.rx_data = 16'h00C8;
    n_total++;
    if (bus.rx_ready !== 1'b0 || bus.port_d_in_1[15:8] !== 8'd8)
      $display("FAIL rx_full got rdy=%b cnt=%0d exp rdy=0 cnt=8", bus.rx_ready, bus.port_d_in_1[15:8]); else n_pass++;
    cyc();
    n_total++;
    if (bus.port_d_in_1 !== 16'h0805) $display("FAIL rx_stall got %h exp 0805", bus.port_d_in_1); else n_pass++;
    pop_rx();
    n_total++;
    if (bus.rx_ready !== 1'b1 || bus.port_d_in_0 !== 16'h00C1 || bus.port_d_in_1[15:8] !== 8'd7)
      $display("FAIL rx_after_pop got rdy=%b d=%h cnt=%0d exp rdy=1 d=00c1 cnt=7", bus.rx_ready, bus.port_d_in_0, bus.port_d_in_1[15:8]); else n_pass++;
    cyc();
    n_total++;
    if (bus.port_d_in_1[15:8] !== 8'd8) $display("FAIL rx_refill got cnt=%0d exp 8", bus.port_d_in_1[15:8]); else n_pass++;
    // reset mid-stream with producer still offering
    bus.rx_data = 16'h00DD;
    push_tx(16'h5555);
    rst = 1'b1;
    cyc();
    n_total++;
    if (bus.port_d_in_0 !== 16'h0000 || bus.port_d_in_1 !== 16'h0004 || bus.tx_valid !== 1'b0)
      $display("FAIL rst_mid got d0=%h st=%h v=%b exp 0000 0004 0", bus.port_d_in_0, bus.port_d_in_1, bus.tx_valid); else n_pass++;
    bus.rx_valid = 1'b0;
    bus.port_d_out_1 = 16'h0000;
    rst = 1'b0;
    cyc();
    n_total++;
    if (bus.port_d_in_0 !== 16'h0000 || bus.port_d_in_1 !== 16'h0004 || bus.rx_ready !== 1'b0)
      $display("FAIL rst_after got d0=%h st=%h rdy=%b exp 0000 0004 0", bus.port_d_in_0, bus.port_d_in_1, bus.rx_ready); else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    cyc();
    test_reset();
    test_tx_order();
    test_tx_overflow();
    test_tx_full_simul();
    test_rx_pop();
    test_rx_full_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
